// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int          MEM_ADDR_W = 10;
    localparam int          WORD_W     = 32;
    localparam logic [31:0] ERR_DATA   = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        ACK_IN,
        MEM_WAIT,
        OUT_VALID
    } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_counter.sv
// 8-bit loadable down-counter; expired is high while the count sits at zero.
module fetch_timeout_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       dec,
    input  logic [7:0] load_val,
    output logic       expired
);

    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != 8'd0)) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == 8'd0);

endmodule

// File: rtl/fetch_stage.sv
// Single-outstanding instruction fetch: PC in via DIR/ack, one memory read, word out via DOR/ack.
// Optional build macro FETCH_STAGE_ALIGN_CHECK_EN rejects PCs with PC[1:0] != 0 without a memory read.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  DIR,
    input  logic [WORD_W-1:0]     data_in,
    output logic                  ack_from_stage,
    output logic                  DOR,
    output logic [WORD_W-1:0]     data_out,
    output logic                  fetch_err,
    input  logic                  ack_to_stage,
    output logic                  mem_en,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0]     mem_di,
    output logic                  mem_we,
    output logic                  burst_en,
    input  logic                  do_ack,
    input  logic [WORD_W-1:0]     mem_do
);

    localparam logic [7:0] TIMEOUT_LOAD = 8'(MEM_TIMEOUT);

    fetch_state_e            state_q, state_d;
    logic [WORD_W-1:0]       pc_q, pc_d;
    logic                    ack_q, ack_d;
    logic                    dor_q, dor_d;
    logic [WORD_W-1:0]       data_q, data_d;
    logic                    err_q, err_d;
    logic                    mem_en_q, mem_en_d;
    logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                    cnt_load, cnt_dec, cnt_expired;
    logic                    misaligned;
    logic                    unused_pc_bits;

`ifdef FETCH_STAGE_ALIGN_CHECK_EN
    assign misaligned     = |pc_q[1:0];
    assign unused_pc_bits = ^pc_q[31:12];
`else
    assign misaligned     = 1'b0;
    assign unused_pc_bits = ^{pc_q[31:12], pc_q[1:0]};
`endif

    fetch_timeout_counter u_timeout (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (TIMEOUT_LOAD),
        .expired  (cnt_expired)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ack_d      = ack_q;
        dor_d      = dor_q;
        data_d     = data_q;
        err_d      = err_q;
        mem_en_d   = mem_en_q;
        mem_addr_d = mem_addr_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (DIR) begin
                    pc_d    = data_in;
                    ack_d   = 1'b1;
                    state_d = ACK_IN;
                end
            end
            ACK_IN: begin
                // Upstream drops DIR on the edge that saw the ack, so DIR is not looked at here.
                ack_d = 1'b0;
                if (misaligned) begin
                    data_d  = ERR_DATA;
                    err_d   = 1'b1;
                    dor_d   = 1'b1;
                    state_d = OUT_VALID;
                end else begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = pc_q[11:2];
                    cnt_load   = 1'b1;
                    state_d    = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                // do_ack takes priority over a simultaneous timeout expiry.
                if (do_ack) begin
                    data_d   = mem_do;
                    err_d    = 1'b0;
                    mem_en_d = 1'b0;
                    dor_d    = 1'b1;
                    state_d  = OUT_VALID;
                end else if (cnt_expired) begin
                    data_d   = ERR_DATA;
                    err_d    = 1'b1;
                    mem_en_d = 1'b0;
                    dor_d    = 1'b1;
                    state_d  = OUT_VALID;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            OUT_VALID: begin
                if (ack_to_stage) begin
                    dor_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            ack_q      <= 1'b0;
            dor_q      <= 1'b0;
            data_q     <= '0;
            err_q      <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ack_q      <= ack_d;
            dor_q      <= dor_d;
            data_q     <= data_d;
            err_q      <= err_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign ack_from_stage = ack_q;
    assign DOR            = dor_q;
    assign data_out       = data_q;
    assign fetch_err      = err_q;
    assign mem_en         = mem_en_q;
    assign mem_addr       = mem_addr_q;
    assign mem_di         = '0;
    assign mem_we         = 1'b0;
    assign burst_en       = 1'b0;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected words queued at PC issue, compared when DOR rises.
module tb_fetch_stage;

    localparam int T = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        DIR = 1'b0;
    logic [31:0] data_in = '0;
    logic        ack_from_stage;
    logic        DOR;
    logic [31:0] data_out;
    logic        fetch_err;
    logic        ack_to_stage = 1'b0;
    logic        mem_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_di;
    logic        mem_we;
    logic        burst_en;
    logic        do_ack = 1'b0;
    logic [31:0] mem_do = '0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    fetch_stage #(.MEM_TIMEOUT(T)) dut (
        .clk            (clk),
        .reset          (reset),
        .DIR            (DIR),
        .data_in        (data_in),
        .ack_from_stage (ack_from_stage),
        .DOR            (DOR),
        .data_out       (data_out),
        .fetch_err      (fetch_err),
        .ack_to_stage   (ack_to_stage),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_di         (mem_di),
        .mem_we         (mem_we),
        .burst_en       (burst_en),
        .do_ack         (do_ack),
        .mem_do         (mem_do)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // delay: do_ack is sampled at edge 1+delay (-1 = never); ack_delay: cycles DOR is held before ack.
    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] rdata, input int delay,
                            input int ack_delay, input bit hold_dir);
        exp_t        e;
        exp_t        got_e;
        int          edge_n;
        int          exp_edge;
        bit          extra_ack;
        logic [9:0]  exp_addr;
        bit          answered;

        answered = (delay >= 0) && (delay <= T + 1);
        e.data   = answered ? rdata : 32'h0;
        e.err    = !answered;
        exp_edge = answered ? 1 + delay : T + 2;
        exp_addr = pc[11:2];
        sb.push_back(e);

        DIR = 1'b1;
        data_in = pc;
        tick();
        check("ack_pulse", ack_from_stage, 1);
        DIR = 1'b0;
        data_in = 32'hDEAD_BEEF;
        tick();
        check("ack_fall", ack_from_stage, 0);
        check("mem_en_rise", mem_en, 1);
        check("mem_addr", mem_addr, exp_addr);

        edge_n = 1;
        extra_ack = 1'b0;
        while (!DOR && edge_n < T + 10) begin
            do_ack = (delay >= 0) && (edge_n + 1 == 1 + delay);
            mem_do = do_ack ? rdata : 32'h5555_AAAA;
            tick();
            do_ack = 1'b0;
            edge_n++;
            if (ack_from_stage) extra_ack = 1'b1;
        end
        check("dor_edge", edge_n, exp_edge);
        check("mem_en_drop", mem_en, 0);
        check("no_recapture", extra_ack, 0);

        if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
            got_e = e;
        end else begin
            got_e = sb.pop_front();
        end
        check("data_out", data_out, got_e.data);
        check("fetch_err", fetch_err, got_e.err);
        $display("fetch pc=%h addr=%h data=%h err=%0b edge=%0d", pc, mem_addr, data_out, fetch_err, edge_n);

        // stray do_ack and DIR while holding output must be ignored
        do_ack = 1'b1;
        mem_do = 32'h1234_5678;
        for (int i = 0; i < ack_delay; i++) begin
            if (hold_dir) begin
                DIR = 1'b1;
                data_in = pc + 32'd4;
            end
            tick();
            check("hold_dor", DOR, 1);
            check("hold_data", data_out, got_e.data);
            check("hold_no_ack", ack_from_stage, 0);
        end
        ack_to_stage = 1'b1;
        tick();
        ack_to_stage = 1'b0;
        do_ack = 1'b0;
        check("dor_fall", DOR, 0);
        check("no_ack_at_out_edge", ack_from_stage, 0);
        DIR = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", ack_from_stage, 0);
        check("rst_dor", DOR, 0);
        check("rst_err", fetch_err, 0);
        check("rst_data", data_out, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("const_outs", {mem_di[0], |mem_di, mem_we, burst_en}, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        do_fetch(32'h0000_0008, 32'hCAFE_0001, 2, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            do_fetch(32'(i * 4), 32'h1000_0000 + 32'(i), i + 1, 0, 1'b0);
        end

        do_fetch(32'h0000_0020, 32'hBAD0_BAD0, -1, 0, 1'b0);
        do_fetch(32'h0000_0100, 32'hA5A5_0100, 3, 5, 1'b1);
        do_fetch(32'hFFFF_F010, 32'hC01D_0000, T + 1, 0, 1'b0);

        // asynchronous reset while a read is outstanding
        DIR = 1'b1;
        data_in = 32'h0000_0040;
        tick();
        DIR = 1'b0;
        repeat (3) tick();
        check("pre_rst_mem_en", mem_en, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_mem_en", mem_en, 0);
        check("async_rst_dor", DOR, 0);
        check("async_rst_addr", mem_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        do_fetch(32'h0000_0044, 32'h0BEE_F044, 1, 1, 1'b0);

`ifdef FETCH_STAGE_ALIGN_CHECK_EN
        DIR = 1'b1;
        data_in = 32'h0000_0006;
        tick();
        check("align_ack", ack_from_stage, 1);
        DIR = 1'b0;
        tick();
        check("align_dor", DOR, 1);
        check("align_err", fetch_err, 1);
        check("align_data", data_out, 0);
        check("align_mem_en", mem_en, 0);
        $display("fetch pc=00000006 misaligned data=%h err=%0b", data_out, fetch_err);
        ack_to_stage = 1'b1;
        tick();
        ack_to_stage = 1'b0;
        check("align_dor_fall", DOR, 0);
`else
        do_fetch(32'h0000_0006, 32'h0BAD_0006, 3, 0, 1'b0);
`endif

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
